// File: rtl/support_seq_pkg.sv
// Shared definitions for the support sequencer: FSM state encoding and the
// width helper for the shared sequencing counter.
package support_seq_pkg;

  typedef enum logic [1:0] {
    SUP_PWRUP = 2'd0,
    SUP_RESET = 2'd1,
    SUP_BOOT  = 2'd2,
    SUP_RUN   = 2'd3
  } sup_state_t;

  // Bits needed to count up to the longest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned dly,
                                            input int unsigned len,
                                            input int unsigned hold);
    int unsigned m;
    int unsigned w;
    m = dly;
    if (len > m) m = len;
    if (hold > m) m = hold;
    w = $clog2(m + 1);
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/support_seq_if.sv
// Core-facing signal group of the support sequencer. The sequencer uses the
// master view; the CPU core (or a bench standing in for it) uses slave.
interface support_seq_if;

  logic sw_reset;
  logic wdog_kick;
  logic reset;
  logic boot;
  logic interrupt;
  logic halt;
  logic wdog_fired;

  modport master (
    input  sw_reset,
    input  wdog_kick,
    output reset,
    output boot,
    output interrupt,
    output halt,
    output wdog_fired
  );

  modport slave (
    output sw_reset,
    output wdog_kick,
    input  reset,
    input  boot,
    input  interrupt,
    input  halt,
    input  wdog_fired
  );

endinterface

// File: rtl/support_debounce.sv
// One push-button channel: 2-flop synchroniser, tick-sampled history,
// hysteretic debounced level and a registered rising-edge pulse.
module support_debounce #(
  parameter int unsigned DEB_LEN = 10
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic tick,
  input  logic button,
  output logic btn_db,
  output logic btn_rise
);

  logic [1:0]         sync;
  logic [DEB_LEN-1:0] shreg;
  logic               db_d;

  // Bring the asynchronous button into the sysclk domain.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], button};
  end

  // Record one synchronised sample per prescaler tick.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)  shreg <= '0;
    else if (tick) shreg <= (shreg << 1) | DEB_LEN'(sync[1]);
  end

  // Level changes only when the whole history agrees; otherwise it holds.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)          btn_db <= 1'b0;
    else if (&shreg)       btn_db <= 1'b1;
    else if (shreg == '0)  btn_db <= 1'b0;
  end

  // Rise pulse lands the clock after the debounced level goes high.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      db_d     <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      db_d     <= btn_db;
      btn_rise <= btn_db & ~db_d;
    end
  end

endmodule

// File: rtl/support_seq.sv
// Power-up / reset / boot sequencer with N-channel button debounce.
// Button 0 requests reset, button 1 requests boot, buttons 2.. raise
// interrupts. Optional watchdog built when SUPPORT_WDOG_EN is defined.
module support_seq
  import support_seq_pkg::*;
#(
  parameter int unsigned NBTN      = 2,
  parameter int unsigned DEB_DIV   = 15,
  parameter int unsigned DEB_LEN   = 10,
  parameter int unsigned RST_DLY   = 10,
  parameter int unsigned RST_LEN   = 40,
  parameter int unsigned BOOT_OVL  = 10,
  parameter int unsigned BOOT_HOLD = 16,
  parameter int unsigned WDOG_W    = 24
) (
  input  logic            sysclk,
  input  logic            reset_n,
  input  logic [NBTN-1:0] button,
  output logic [NBTN-1:0] btn_db,
  output logic [NBTN-1:0] btn_rise,
  support_seq_if.master   core
);

  localparam int unsigned   CW        = cnt_width(RST_DLY, RST_LEN, BOOT_HOLD);
  localparam logic [CW-1:0] DLY_LAST  = CW'(RST_DLY - 1);
  localparam logic [CW-1:0] LEN_LAST  = CW'(RST_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(BOOT_HOLD - 1);
  localparam logic [CW-1:0] BOOT_FROM = CW'(RST_LEN - BOOT_OVL);

  logic [DEB_DIV-1:0] pre;
  logic               tick;
  sup_state_t         state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               rst_req;
  logic               wdog_exp;

  // Free-running debounce prescaler; a tick each time it wraps to zero.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) pre <= '0;
    else          pre <= pre + DEB_DIV'(1);
  end

  assign tick = (pre == '0);

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    support_debounce #(
      .DEB_LEN (DEB_LEN)
    ) u_db (
      .sysclk   (sysclk),
      .reset_n  (reset_n),
      .tick     (tick),
      .button   (button[g]),
      .btn_db   (btn_db[g]),
      .btn_rise (btn_rise[g])
    );
  end

  if (NBTN > 2) begin : g_irq
    assign core.interrupt = |btn_rise[NBTN-1:2];
  end else begin : g_no_irq
    assign core.interrupt = 1'b0;
  end

`ifdef SUPPORT_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_fired_q;

  // A kick on the expiry clock suppresses the expiry.
  assign wdog_exp = (state == SUP_RUN) && (wdog_cnt == '1) && !core.wdog_kick;

  // Watchdog only counts in RUN; leaving RUN or a kick restarts it.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt     <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      if (state != SUP_RUN || core.wdog_kick) wdog_cnt <= '0;
      else if (wdog_cnt != '1)                wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (wdog_exp) wdog_fired_q <= 1'b1;
    end
  end

  assign core.wdog_fired = wdog_fired_q;
`else
  logic [WDOG_W-1:0] unused_wdog;
  assign unused_wdog     = {WDOG_W{core.wdog_kick}};
  assign wdog_exp        = 1'b0;
  assign core.wdog_fired = 1'b0;
`endif

  assign rst_req = btn_db[0] | core.sw_reset | wdog_exp;

  // Sequencer state and shared phase counter.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SUP_PWRUP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Phase sequencing; any reset request (outside PWRUP) re-enters RESET at 0,
  // which also keeps the count pinned while the reset button is held.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      SUP_PWRUP: begin
        if (cnt == DLY_LAST) begin
          state_nxt = SUP_RESET;
          cnt_nxt   = '0;
        end
      end
      SUP_RESET: begin
        if (rst_req) begin
          cnt_nxt = '0;
        end else if (cnt == LEN_LAST) begin
          state_nxt = SUP_BOOT;
          cnt_nxt   = '0;
        end
      end
      SUP_BOOT: begin
        if (rst_req) begin
          state_nxt = SUP_RESET;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = SUP_RUN;
          cnt_nxt   = '0;
        end
      end
      SUP_RUN: begin
        cnt_nxt = '0;
        if (rst_req) state_nxt = SUP_RESET;
      end
      default: begin
        state_nxt = SUP_PWRUP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Core-facing outputs decoded from state so reset_n acts without a clock.
  always_comb begin
    core.reset = (state == SUP_PWRUP) || (state == SUP_RESET);
    core.boot  = ((state == SUP_RESET) && (cnt >= BOOT_FROM)) ||
                 (state == SUP_BOOT) ||
                 ((state == SUP_RUN) && btn_db[1]);
    core.halt  = 1'b0;
  end

endmodule
